// File: rtl/ext_mem_pkg.sv
// Shared widths and FSM state type for the external line-memory responder.
package ext_mem_pkg;
    localparam int LINE_W   = 256;
    localparam int OFFSET_W = 5;
    localparam int ADDR_W   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        TURN = 2'd3
    } ext_mem_state_t;
endpackage

// File: rtl/ext_mem_array.sv
// Single-port line storage: synchronous write, registered read. Contents are not reset;
// only the read register is. A clear read returns zero instead of the stored line.
module ext_mem_array
    import ext_mem_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic              clr,
    input  logic [IDX_W-1:0]  idx,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata
);
    logic [LINE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= clr ? '0 : mem[idx];
        end
    end
endmodule

// File: rtl/ext_mem_responder.sv
// Fixed-latency responder for the cache's 256-bit external line port.
// Optional bounds check: define EXT_MEM_BOUNDS_CHECK_EN to flag addresses >= DEPTH*32.
//
// state | meaning
// IDLE  | waiting for cs_i; captures the request when it is seen
// WAIT  | latency countdown, inputs ignored
// ACK   | one-cycle ack; write commits, read data already on data_o
// TURN  | dead cycle so a lingering cs_i is not taken as a new request
module ext_mem_responder
    import ext_mem_pkg::*;
#(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              cs_i,
    input  logic              we_i,
    input  logic [LINE_W-1:0] data_i,
    output logic [LINE_W-1:0] data_o,
    output logic              ack_o,
    output logic              err_o
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    ext_mem_state_t    state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  req_idx;
    logic              req_oor;
    logic              req_we;
    logic [LINE_W-1:0] req_data;

    logic [IDX_W-1:0]  in_idx;
    logic              in_oor;
    logic              go_ack;
    logic [IDX_W-1:0]  acc_idx;
    logic              acc_oor;
    logic              acc_we;
    logic              mem_en;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;

    assign in_idx = addr_i[OFFSET_W +: IDX_W];
`ifdef EXT_MEM_BOUNDS_CHECK_EN
    assign in_oor = |addr_i[ADDR_W-1:OFFSET_W+IDX_W];
`else
    assign in_oor = 1'b0;
`endif

    // The read is issued the cycle before ACK so the registered data lands with the ack.
    // With LATENCY=1 that cycle is the capture cycle, so the live inputs are used.
    always_comb begin
        go_ack  = 1'b0;
        acc_idx = req_idx;
        acc_oor = req_oor;
        acc_we  = req_we;
        case (state)
            IDLE: begin
                acc_idx = in_idx;
                acc_oor = in_oor;
                acc_we  = we_i;
                go_ack  = cs_i && (LATENCY == 1);
            end
            WAIT:    go_ack = (cnt <= CNT_W'(1));
            default: go_ack = 1'b0;
        endcase
    end

    assign mem_we  = (state == ACK);
    assign mem_idx = mem_we ? req_idx : acc_idx;
    assign mem_en  = !rst && ((go_ack && !acc_we) || (mem_we && req_we && !req_oor));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            req_idx  <= '0;
            req_oor  <= 1'b0;
            req_we   <= 1'b0;
            req_data <= '0;
            ack_o    <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_i) begin
                        req_idx  <= in_idx;
                        req_oor  <= in_oor;
                        req_we   <= we_i;
                        req_data <= data_i;
                        cnt      <= CNT_W'(LATENCY - 1);
                        state    <= go_ack ? ACK : WAIT;
                        ack_o    <= go_ack;
                        err_o    <= go_ack && in_oor;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (go_ack) begin
                        state <= ACK;
                        ack_o <= 1'b1;
                        err_o <= req_oor;
                    end
                end
                ACK:     state <= TURN;
                default: state <= IDLE;
            endcase
        end
    end

    ext_mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .en    (mem_en),
        .we    (mem_we),
        .clr   (acc_oor),
        .idx   (mem_idx),
        .wdata (req_data),
        .rdata (data_o)
    );
endmodule

// File: tb/tb_ext_mem_responder.sv
// Directed bench for ext_mem_responder at LATENCY=10, DEPTH=512.
module tb_ext_mem_responder;
    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  addr_i;
    logic         cs_i;
    logic         we_i;
    logic [255:0] data_i;
    logic [255:0] data_o;
    logic         ack_o;
    logic         err_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [255:0] ack_data;
    logic         ack_err;
    int           lat;

    localparam logic [255:0] PAT_A5 = {32{8'hA5}};
    localparam logic [255:0] PAT_5A = {32{8'h5A}};
    localparam logic [255:0] PAT_P  = {4{64'h0123_4567_89AB_CDEF}};
    localparam logic [255:0] PAT_Q  = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] PAT_R  = {16{16'h3C96}};

    ext_mem_responder #(.LATENCY(10), .DEPTH(512)) dut (
        .clk    (clk),
        .rst    (rst),
        .addr_i (addr_i),
        .cs_i   (cs_i),
        .we_i   (we_i),
        .data_i (data_i),
        .data_o (data_o),
        .ack_o  (ack_o),
        .err_o  (err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Issues one request in the current (IDLE) cycle, waits for ack, then returns in the
    // next IDLE cycle. lat = cycles from capture to ack (40 means no ack seen).
    task automatic do_req(input logic [31:0] a, input logic w, input logic [255:0] d,
                          output int l);
        addr_i = a;
        we_i   = w;
        data_i = d;
        cs_i   = 1'b1;
        l = 0;
        while (l < 40) begin
            tick();
            l++;
            if (ack_o) break;
        end
        ack_data = data_o;
        ack_err  = err_o;
        cs_i = 1'b0;
        tick();
        check("ack_one_cycle", {255'b0, ack_o}, 256'd0);
        tick();
    endtask

    initial begin
        int acks;
        int second;
        rst    = 1'b1;
        cs_i   = 1'b0;
        we_i   = 1'b0;
        addr_i = '0;
        data_i = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_ack", {255'b0, ack_o}, 256'd0);
        check("reset_err", {255'b0, err_o}, 256'd0);
        check("reset_data", data_o, 256'd0);

        do_req(32'h0000_0040, 1'b1, PAT_A5, lat);
        check("wr_latency", lat, 10);
        check("wr_err", {255'b0, ack_err}, 256'd0);
        check("data_held_on_write", data_o, 256'd0);

        do_req(32'h0000_0040, 1'b0, '0, lat);
        check("rd_latency", lat, 10);
        check("rd_data", ack_data, PAT_A5);

        do_req(32'h0000_0020, 1'b1, PAT_P, lat);
        do_req(32'h0000_003F, 1'b0, '0, lat);
        check("offset_ignore", ack_data, PAT_P);
        do_req(32'h0000_0000, 1'b1, PAT_Q, lat);

`ifndef EXT_MEM_BOUNDS_CHECK_EN
        do_req(32'h0000_4020, 1'b0, '0, lat);
        check("wrap_read", ack_data, PAT_P);
        check("wrap_err", {255'b0, ack_err}, 256'd0);
        do_req(32'h0000_4060, 1'b1, PAT_R, lat);
        do_req(32'h0000_0060, 1'b0, '0, lat);
        check("wrap_write", ack_data, PAT_R);
`else
        do_req(32'h0001_0000, 1'b0, '0, lat);
        check("oor_rd_latency", lat, 10);
        check("oor_rd_err", {255'b0, ack_err}, 256'd1);
        check("oor_rd_data", ack_data, 256'd0);
        do_req(32'h0001_0000, 1'b1, PAT_R, lat);
        check("oor_wr_err", {255'b0, ack_err}, 256'd1);
        do_req(32'h0000_0000, 1'b0, '0, lat);
        check("oor_wr_dropped", ack_data, PAT_Q);
        check("inrange_err", {255'b0, ack_err}, 256'd0);
`endif

        // cs_i left high through TURN and the following IDLE: exactly one new request.
        addr_i = 32'h0000_0040;
        we_i   = 1'b0;
        cs_i   = 1'b1;
        lat = 0;
        while (lat < 40) begin
            tick();
            lat++;
            if (ack_o) break;
        end
        check("turn_first_latency", lat, 10);
        acks   = 0;
        second = -1;
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (c == 3) cs_i = 1'b0;
            if (ack_o) begin
                acks++;
                if (second < 0) second = c;
            end
        end
        check("turn_ack_count", acks, 1);
        check("turn_second_gap", second, 12);
        check("turn_data", data_o, PAT_A5);

        // Reset during WAIT drops the write and the ack.
        addr_i = 32'h0000_0040;
        we_i   = 1'b1;
        data_i = PAT_5A;
        cs_i   = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        cs_i = 1'b0;
        check("midrst_data_cleared", data_o, 256'd0);
        acks = 0;
        for (int c = 0; c < 15; c++) begin
            if (ack_o) acks++;
            tick();
        end
        check("midrst_no_ack", acks, 0);
        do_req(32'h0000_0040, 1'b0, '0, lat);
        check("midrst_rd_latency", lat, 10);
        check("midrst_write_dropped", ack_data, PAT_A5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
